vga_frame_reader: RTL and testbench



---
 rtl/vga_reader_pkg.sv | 18 +
 rtl/pixel_fifo.sv | 57 +++++
 rtl/vga_frame_reader.sv | 135 +++++++++++++
 tb/tb_vga_frame_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_reader_pkg.sv
// Shared types and width helpers for the VGA frame reader and its pixel FIFO.
package vga_reader_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

  localparam int BYTES_PER_PIXEL = 4;

  // Width of an index into n items (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of a counter that must hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: rdata always presents the head entry while !empty.
module pixel_fifo
  import vga_reader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      rd,
  output logic [WIDTH-1:0]          rdata,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   free
);

  localparam int AW = idx_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr, do_rd;

  assign empty = (count == '0);
  assign free  = CW'(DEPTH) - count;
  assign rdata = mem[rd_ptr];

  // Flush dominates both ports; a pop makes room for a same-cycle push.
  assign do_rd = rd && !empty && !flush;
  assign do_wr = wr && !flush && ((count != CW'(DEPTH)) || do_rd);

  // NOTE: the storage array is deliberately not reset; count and pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Avalon burst-read host streaming the frame buffer into a show-ahead pixel FIFO.
// Optional statistics outputs (underflow_cnt, frame_cnt) under `VGA_FRAME_READER_STATS_EN.
module vga_frame_reader
  import vga_reader_pkg::*;
#(
  parameter int          HDISP        = 800,
  parameter int          VDISP        = 480,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          BURST        = 16,
  parameter int          BURSTCOUNT_W = 6,
  parameter int          FIFO_DEPTH   = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [31:0]             avm_address,
  output logic                    avm_read,
  output logic [BURSTCOUNT_W-1:0] avm_burstcount,
  input  logic [31:0]             avm_readdata,
  input  logic                    avm_readdatavalid,
  input  logic                    avm_waitrequest,
  input  logic                    frame_restart,
  input  logic                    pix_rd,
  output logic [31:0]             pix_data,
  output logic                    pix_empty,
  output logic                    underflow,
  output logic                    frame_done
`ifdef VGA_FRAME_READER_STATS_EN
  ,
  output logic [15:0]             underflow_cnt,
  output logic [15:0]             frame_cnt
`endif
);

  localparam int          TOTAL     = HDISP * VDISP;
  localparam int          PIX_W     = idx_w(TOTAL);
  localparam int          BEAT_W    = idx_w(BURST);
  localparam int          FCW       = cnt_w(FIFO_DEPTH);
  localparam logic [31:0] ADDR_STEP = 32'(BURST * BYTES_PER_PIXEL);

  state_t             state, state_nxt;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [PIX_W-1:0]   pix_cnt;
  logic [FCW-1:0]     fifo_free;
  logic               accept, last_beat, burst_done, frame_end, fifo_wr;

  assign avm_read       = (state == REQ);
  assign avm_burstcount = BURSTCOUNT_W'(BURST);

  assign accept     = avm_read && !avm_waitrequest;
  assign last_beat  = avm_readdatavalid && (beat_cnt == BEAT_W'(BURST - 1));
  assign fifo_wr    = (state == DATA) && avm_readdatavalid && !frame_restart;
  assign burst_done = (state == DATA) && last_beat && !frame_restart;
  assign frame_end  = (pix_cnt == PIX_W'(TOTAL - BURST));

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fifo_free >= FCW'(BURST)) state_nxt = REQ;
      REQ: begin
        if (accept)             state_nxt = frame_restart ? DRAIN : DATA;
        else if (frame_restart) state_nxt = IDLE;
      end
      // A restart coinciding with the final beat leaves nothing to drain.
      DATA: begin
        if (last_beat)          state_nxt = IDLE;
        else if (frame_restart) state_nxt = DRAIN;
      end
      DRAIN: if (last_beat)     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      pix_cnt     <= '0;
      avm_address <= BASE_ADDR;
      underflow   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= burst_done && frame_end;

      if (accept)
        beat_cnt <= '0;
      else if ((state == DATA || state == DRAIN) && avm_readdatavalid)
        beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);

      if (frame_restart) begin
        avm_address <= BASE_ADDR;
        pix_cnt     <= '0;
      end else if (burst_done) begin
        avm_address <= frame_end ? BASE_ADDR : avm_address + ADDR_STEP;
        pix_cnt     <= frame_end ? '0 : pix_cnt + PIX_W'(BURST);
      end

      if (frame_restart)
        underflow <= 1'b0;
      else if (pix_rd && pix_empty)
        underflow <= 1'b1;
    end
  end

`ifdef VGA_FRAME_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_cnt <= '0;
      frame_cnt     <= '0;
    end else begin
      if (pix_rd && pix_empty && underflow_cnt != 16'hFFFF)
        underflow_cnt <= underflow_cnt + 16'd1;
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_restart),
    .wr    (fifo_wr),
    .wdata (avm_readdata),
    .rd    (pix_rd),
    .rdata (pix_data),
    .empty (pix_empty),
    .free  (fifo_free)
  );

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: random Avalon slave, random consumer, reference model.
module tb_vga_frame_reader;

  localparam int          HDISP = 8;
  localparam int          VDISP = 4;
  localparam int          BURST = 4;
  localparam int          BCW   = 6;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          TOTAL = HDISP * VDISP;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     avm_address, avm_readdata, pix_data;
  logic            avm_read, avm_readdatavalid, avm_waitrequest;
  logic [BCW-1:0]  avm_burstcount;
  logic            frame_restart, pix_rd, pix_empty, underflow, frame_done;
`ifdef VGA_FRAME_READER_STATS_EN
  logic [15:0]     underflow_cnt, frame_cnt;
`endif

  vga_frame_reader #(
    .HDISP(HDISP), .VDISP(VDISP), .BASE_ADDR(BASE), .BURST(BURST),
    .BURSTCOUNT_W(BCW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest), .frame_restart(frame_restart), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_empty(pix_empty), .underflow(underflow), .frame_done(frame_done)
`ifdef VGA_FRAME_READER_STATS_EN
    , .underflow_cnt(underflow_cnt), .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Memory contents as a function of byte address.
  function automatic logic [31:0] pixel_word(input logic [31:0] addr);
    return addr ^ {addr[15:0], 16'hBEEF};
  endfunction

  function automatic logic [31:0] pixel_addr(input int idx);
    return BASE + 32'(idx * 4);
  endfunction

  // Stimulus knobs (percent / per-mille) and Avalon slave state.
  int unsigned wait_pct = 0, valid_pct = 100, rd_pct = 0, restart_pm = 0;
  logic        restart_req = 1'b0;
  logic [31:0] slave_q[$];
  logic [31:0] slave_addr = '0;
  int          slave_left = 0;

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    avm_waitrequest = ($urandom_range(99) < wait_pct);
    if (slave_left == 0 && slave_q.size() > 0) begin
      slave_addr = slave_q.pop_front();
      slave_left = BURST;
    end
    avm_readdatavalid = 1'b0;
    if (slave_left > 0 && $urandom_range(99) < valid_pct) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = pixel_word(slave_addr);
      slave_addr        = slave_addr + 32'd4;
      slave_left--;
    end
    pix_rd        = ($urandom_range(99) < rd_pct);
    frame_restart = restart_req || ($urandom_range(999) < restart_pm);
    restart_req   = 1'b0;
  endtask

  // Reference model: frame as a linear sequence of pixel indices.
  int          exp_q[$];      // pixels committed to the FIFO, head first
  int          pend_q[$];     // pixels of the accepted burst still to arrive
  int          stale = 0;     // beats of a burst orphaned by a restart
  int          p_next = 0;    // pixel index of the next burst request
  logic        uf_m = 1'b0, fd_m = 1'b0;
  logic [15:0] ucnt_m = '0, fcnt_m = '0;
  int          acc_cnt = 0, model_fd = 0, dut_fd = 0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_addr = '0;
  logic        pre_empty, accept;
  int          pre_occ, pre_outst, idx;

  always @(negedge clk) begin
    if (!rst) begin
      pre_empty = (exp_q.size() == 0);
      pre_occ   = exp_q.size();
      pre_outst = pend_q.size() + stale;
      accept    = avm_read && !avm_waitrequest;

      check("pix_empty", 32'(pix_empty), 32'(pre_empty));
      check("underflow", 32'(underflow), 32'(uf_m));
      check("frame_done", 32'(frame_done), 32'(fd_m));
`ifdef VGA_FRAME_READER_STATS_EN
      check("underflow_cnt", 32'(underflow_cnt), 32'(ucnt_m));
      check("frame_cnt", 32'(frame_cnt), 32'(fcnt_m));
`endif
      if (hold_prev) begin
        check("req_hold_read", 32'(avm_read), 32'd1);
        check("req_hold_addr", avm_address, hold_addr);
        check("req_hold_count", 32'(avm_burstcount), 32'(BURST));
      end
      hold_prev = avm_read && avm_waitrequest && !frame_restart;
      hold_addr = avm_address;

      if (fd_m) begin model_fd++; fcnt_m = fcnt_m + 16'd1; end
      if (frame_done) dut_fd++;

      if (pix_rd && pre_empty && ucnt_m != 16'hFFFF) ucnt_m = ucnt_m + 16'd1;
      uf_m = frame_restart ? 1'b0 : (uf_m | (pix_rd && pre_empty));

      if (pix_rd && !pre_empty && !frame_restart)
        check("pix_data", pix_data, pixel_word(pixel_addr(exp_q.pop_front())));

      fd_m = 1'b0;
      if (avm_readdatavalid) begin
        if (stale > 0) stale--;
        else if (pend_q.size() > 0) begin
          idx = pend_q.pop_front();
          if (!frame_restart) begin
            exp_q.push_back(idx);
            if (idx == TOTAL - 1) fd_m = 1'b1;
          end
        end
      end

      if (frame_restart) begin
        exp_q.delete();
        stale += pend_q.size();
        pend_q.delete();
      end

      if (accept) begin
        acc_cnt++;
        slave_q.push_back(avm_address);
        check("burst_addr", avm_address, pixel_addr(p_next));
        check("burstcount", 32'(avm_burstcount), 32'(BURST));
        check("one_outstanding", 32'(pre_outst), 32'd0);
        check("free_space_ok", 32'(pre_occ <= DEPTH - BURST), 32'd1);
        if (frame_restart) stale += BURST;
        else for (int i = 0; i < BURST; i++) pend_q.push_back(p_next + i);
        p_next = (p_next + BURST) % TOTAL;
      end
      if (frame_restart) p_next = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int acc0;
  logic found;

  initial begin
    rst = 1'b1;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    frame_restart = 1'b0; pix_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avm_read", 32'(avm_read), 32'd0);
    check("rst_avm_address", avm_address, BASE);
    check("rst_burstcount", 32'(avm_burstcount), 32'(BURST));
    check("rst_pix_empty", 32'(pix_empty), 32'd1);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Streaming with an ideal slave.
    wait_pct = 0; valid_pct = 100; rd_pct = 70;
    repeat (400) drive_cycle();
    check("frame_done_count", 32'(dut_fd), 32'(model_fd));
    check("frames_completed", 32'(model_fd >= 3), 32'd1);

    // Stalls, gapped beats, random restarts.
    wait_pct = 50; valid_pct = 60; rd_pct = 60; restart_pm = 15;
    repeat (2500) drive_cycle();
    restart_pm = 0;

    // Back-pressure: no pops, FIFO fills to exactly DEPTH/BURST bursts.
    wait_pct = 0; valid_pct = 100; rd_pct = 0;
    repeat (40) drive_cycle();
    restart_req = 1'b1;
    drive_cycle();
    drive_cycle();
    acc0 = acc_cnt;
    repeat (150) drive_cycle();
    check("fill_bursts", 32'(acc_cnt - acc0), 32'(DEPTH / BURST));
    check("fill_read_idle", 32'(avm_read), 32'd0);
    rd_pct = 100;
    repeat (4) drive_cycle();
    rd_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      drive_cycle();
      if (acc_cnt - acc0 == DEPTH / BURST + 1) found = 1'b1;
    end
    check("refill_burst", 32'(found), 32'd1);

    // Restart after beat 2 of a burst.
    repeat (20) drive_cycle();
    rd_pct = 100;
    repeat (10) drive_cycle();
    rd_pct = 0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      drive_cycle();
      if (avm_readdatavalid && slave_left == BURST - 2) found = 1'b1;
    end
    check("beat2_seen", 32'(found), 32'd1);
    restart_req = 1'b1;
    drive_cycle();
    drive_cycle();
    check("restart_empty", 32'(pix_empty), 32'd1);
    check("restart_underflow", 32'(underflow), 32'd0);
    repeat (30) drive_cycle();

    // Underflow stickiness.
    restart_req = 1'b1;
    drive_cycle();
    rd_pct = 100;
    drive_cycle();
    rd_pct = 0;
    drive_cycle();
    check("underflow_set", 32'(underflow), 32'd1);
    repeat (10) drive_cycle();
    check("underflow_held", 32'(underflow), 32'd1);
    restart_req = 1'b1;
    drive_cycle();
    drive_cycle();
    check("underflow_cleared", 32'(underflow), 32'd0);
    repeat (30) drive_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
